// File: rtl/mem_pkg.sv
// Shared types for the data-memory path.
// Write-buffer FSM states, FIFO entry layout and SRAM base offset.
package mem_pkg;

    localparam int SRAM_BASE = 1024;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WR    = 2'd1,
        S_RD    = 2'd2,
        S_RDONE = 2'd3
    } wb_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO for posted stores.
// Pointers carry an extra wrap bit so full and empty are distinct.
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [PW:0]  wr_ptr;
    logic [PW:0]  rd_ptr;

    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                   (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign head  = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[PW-1:0]] <= din;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/sram_write_buffer.sv
// Posted-write buffer in front of the SRAM controller.
// Stores are acked at once and drained in order; reads wait for the drain.
module sram_write_buffer
    import mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_req,
    input  logic                   rd_req,
    input  logic [AW-1:0]          addr,
    input  logic [DW-1:0]          wdata,
    output logic                   ready,
    output logic [63:0]            rdata,
    output logic                   sram_wr_en,
    output logic                   sram_rd_en,
    output logic [AW-1:0]          sram_addr,
    output logic [DW-1:0]          sram_wdata,
    input  logic [63:0]            sram_rdata,
    input  logic                   sram_ready,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    wb_state_t         state;
    logic [AW+DW-1:0]  head;
    logic              full;
    logic              push;
    logic              pop;
    logic              wr_next;
    logic              rd_next;

    assign push  = wr_req && !full;
    assign pop   = (state == S_WR) && sram_ready;
    assign ready = push || (state == S_RDONE);

    // Commands drop on the completing edge so the controller never sees a repeat.
    assign wr_next = (state == S_WR) && !sram_ready;
    assign rd_next = (state == S_RD) && !sram_ready;

    wb_fifo #(
        .DEPTH (DEPTH),
        .W     (AW + DW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({addr, wdata}),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            rdata      <= '0;
            sram_wr_en <= 1'b0;
            sram_rd_en <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (!empty)
                        state <= S_WR;
                    else if (rd_req && !wr_req)
                        state <= S_RD;
                end
                S_WR: begin
                    if (sram_ready)
                        state <= S_IDLE;
                end
                S_RD: begin
                    if (sram_ready) begin
                        rdata <= sram_rdata;
                        state <= S_RDONE;
                    end
                end
                S_RDONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            sram_wr_en <= wr_next;
            sram_rd_en <= rd_next;

            if (wr_next)
                sram_addr <= head[AW+DW-1:DW];
            else if (rd_next)
                sram_addr <= addr;
            else
                sram_addr <= '0;

            sram_wdata <= wr_next ? head[DW-1:0] : '0;
        end
    end

endmodule

// File: tb/tb_sram_write_buffer.sv
// Self-checking bench for sram_write_buffer.
// Includes a behavioural SRAM controller and a queue-based reference model.
module tb_sram_write_buffer;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        wr_req;
    logic        rd_req;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic [63:0] rdata;
    logic        sram_wr_en;
    logic        sram_rd_en;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [63:0] sram_rdata;
    logic        sram_ready;
    logic        empty;
    logic [2:0]  count;

    int tests;
    int fails;

    // Controller model: answers after the enable was seen high on ctl_lat edges.
    int          ctl_lat;
    int          ctl_cnt;
    bit          ctl_stall;
    bit          ctl_wr_done;
    logic [63:0] ctl_mem [logic [31:0]];
    logic [63:0] wr_log [$];

    sram_write_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_req     (wr_req),
        .rd_req     (rd_req),
        .addr       (addr),
        .wdata      (wdata),
        .ready      (ready),
        .rdata      (rdata),
        .sram_wr_en (sram_wr_en),
        .sram_rd_en (sram_rd_en),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .sram_ready (sram_ready),
        .empty      (empty),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mem_word(input logic [31:0] a,
                                             input logic [31:0] d);
        return {a ^ 32'hA5A5_0000, d};
    endfunction

    function automatic logic [63:0] mem_default(input logic [31:0] a);
        return {a, ~a};
    endfunction

    task automatic ctl_step();
        ctl_wr_done = 1'b0;
        if (!rst) begin
            ctl_cnt    = 0;
            sram_ready = 1'b0;
        end else if ((sram_wr_en || sram_rd_en) && !ctl_stall) begin
            ctl_cnt++;
            if (sram_rd_en)
                sram_rdata = ctl_mem.exists(sram_addr) ?
                             ctl_mem[sram_addr] : mem_default(sram_addr);
            if (ctl_cnt >= ctl_lat) begin
                sram_ready = 1'b1;
                if (sram_wr_en) begin
                    ctl_wr_done = 1'b1;
                    wr_log.push_back({sram_addr, sram_wdata});
                    ctl_mem[sram_addr] = mem_word(sram_addr, sram_wdata);
                end
            end else begin
                sram_ready = 1'b0;
            end
        end else begin
            ctl_cnt    = 0;
            sram_ready = 1'b0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        ctl_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int max);
        for (int k = 0; k < max; k++) begin
            if (empty && !sram_wr_en) break;
            tick();
        end
        chk("drain_done", 64'(empty && !sram_wr_en), 64'd1);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        int          lat;
        logic        exp_ready;
        int          exp_en_edge;
    } vec_t;

    vec_t tbl [4];

    logic [63:0] q [$];
    logic [31:0] mdl_last [logic [31:0]];

    initial begin
        int          first;
        int          nready;
        int          edge_seen;
        bit          early;
        bit          got;
        bit          rd_active;
        bit          drop_rd;
        bit          wr_hold;
        bit          exp_acc;
        int          rd_age;
        int          r;
        logic [31:0] ra;
        logic [63:0] exp_rd;

        tests = 0;
        fails = 0;
        tbl[0] = '{32'h0000_0408, 32'hDEAD_BEEF, 1, 1'b1, 2};
        tbl[1] = '{32'h0000_0000, 32'h0000_0000, 2, 1'b1, 2};
        tbl[2] = '{32'hFFFF_FFFC, 32'hFFFF_FFFF, 3, 1'b1, 2};
        tbl[3] = '{32'h0000_1234, 32'hA5A5_A5A5, 1, 1'b1, 2};

        rst = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
        addr = '0; wdata = '0; sram_ready = 1'b0; sram_rdata = '0;
        ctl_lat = 1; ctl_stall = 1'b0; ctl_cnt = 0; ctl_wr_done = 1'b0;

        tick();
        tick();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_en", 64'({sram_wr_en, sram_rd_en}), 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_cmd", {sram_addr, sram_wdata}, 64'd0);
        rst = 1'b1;
        tick();

        // Single stores from the table.
        foreach (tbl[i]) begin
            wr_log.delete();
            ctl_lat = tbl[i].lat;
            wr_req = 1'b1; addr = tbl[i].a; wdata = tbl[i].d;
            #1;
            chk("st_ready", 64'(ready), 64'(tbl[i].exp_ready));
            tick();
            wr_req = 1'b0;
            edge_seen = -1;
            for (int e = 1; e <= 4; e++) begin
                if (sram_wr_en && edge_seen < 0) begin
                    edge_seen = e - 1;
                    chk("st_cmd", {sram_addr, sram_wdata}, {tbl[i].a, tbl[i].d});
                end
                tick();
            end
            chk("st_en_edge", 64'(edge_seen), 64'(tbl[i].exp_en_edge));
            drain(20);
            chk("st_empty", 64'(empty), 64'd1);
            chk("st_log", 64'(wr_log.size()), 64'd1);
            if (wr_log.size() == 1)
                chk("st_log_val", wr_log[0], {tbl[i].a, tbl[i].d});
        end

        // Fill past DEPTH with the controller stalled.
        wr_log.delete();
        ctl_stall = 1'b1;
        ctl_lat = 1;
        for (int i = 0; i < 4; i++) begin
            wr_req = 1'b1; addr = 32'h500 + 32'(4 * i); wdata = 32'h1000 + 32'(i);
            #1;
            chk("fill_ack", 64'(ready), 64'd1);
            tick();
        end
        addr = 32'h510; wdata = 32'h1004;
        #1;
        chk("fill_full_ready", 64'(ready), 64'd0);
        chk("fill_count", 64'(count), 64'd4);
        tick();
        chk("fill_still_full", 64'(ready), 64'd0);
        chk("fill_wr_en", 64'(sram_wr_en), 64'd1);
        ctl_stall = 1'b0;
        @(negedge clk);
        ctl_step();
        chk("full_pop_ready", 64'(ready), 64'd0);
        @(posedge clk);
        #1;
        chk("fill_after_pop_ready", 64'(ready), 64'd1);
        chk("fill_after_pop_count", 64'(count), 64'd3);
        tick();
        wr_req = 1'b0;
        drain(60);
        chk("fill_log_n", 64'(wr_log.size()), 64'd5);
        for (int i = 0; i < 5 && i < wr_log.size(); i++)
            chk("fill_order", wr_log[i], {32'h500 + 32'(4 * i), 32'h1000 + 32'(i)});

        // Concurrent write and read: only the write counts.
        wr_log.delete();
        wr_req = 1'b1; rd_req = 1'b1; addr = 32'h600; wdata = 32'h0BAD_F00D;
        #1;
        chk("both_ready", 64'(ready), 64'd1);
        tick();
        wr_req = 1'b0; rd_req = 1'b0;
        chk("both_count", 64'(count), 64'd1);
        early = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (sram_rd_en) early = 1'b1;
            tick();
        end
        chk("both_no_read", 64'(early), 64'd0);
        chk("both_log", 64'(wr_log.size()), 64'd1);
        if (wr_log.size() == 1)
            chk("both_log_val", wr_log[0], {32'h600, 32'h0BAD_F00D});

        // Read after write: read must wait for the store.
        wr_log.delete();
        ctl_lat = 2;
        wr_req = 1'b1; addr = 32'h400; wdata = 32'h55AA_55AA;
        #1;
        chk("raw_wr_ack", 64'(ready), 64'd1);
        tick();
        wr_req = 1'b0; rd_req = 1'b1;
        early = 1'b0; got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (sram_rd_en && wr_log.size() == 0) early = 1'b1;
            if (ready) begin got = 1'b1; break; end
        end
        chk("raw_order", 64'(early), 64'd0);
        chk("raw_ready", 64'(got), 64'd1);
        chk("raw_rdata", rdata, 64'hA5A5_0400_55AA_55AA);
        tick();
        rd_req = 1'b0;
        chk("raw_ready_one", 64'(ready), 64'd0);
        tick();

        // Read on empty with controller latency 5.
        ctl_lat = 5;
        rd_req = 1'b1; addr = 32'h800;
        tick();
        first = -1; nready = 0;
        for (int j = 1; j <= 12; j++) begin
            tick();
            if (ready) begin
                nready++;
                if (first < 0) first = j;
            end
            if (first >= 0 && j == first + 1) rd_req = 1'b0;
        end
        rd_req = 1'b0;
        chk("rd_latency", 64'(first), 64'd6);
        chk("rd_ready_cycles", 64'(nready), 64'd1);
        chk("rd_rdata", rdata, 64'h0000_0800_FFFF_F7FF);
        tick();

        // Reset while a write is in flight with three queued entries.
        ctl_stall = 1'b1;
        ctl_lat = 1;
        for (int i = 0; i < 3; i++) begin
            wr_req = 1'b1; addr = 32'h700 + 32'(4 * i); wdata = 32'h7000 + 32'(i);
            tick();
        end
        wr_req = 1'b0;
        tick();
        tick();
        chk("rstwr_pre_count", 64'(count), 64'd3);
        chk("rstwr_pre_en", 64'(sram_wr_en), 64'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("rstwr_count", 64'(count), 64'd0);
        chk("rstwr_empty", 64'(empty), 64'd1);
        chk("rstwr_en", 64'({sram_wr_en, sram_rd_en}), 64'd0);
        chk("rstwr_rdata", rdata, 64'd0);
        chk("rstwr_cmd", {sram_addr, sram_wdata}, 64'd0);
        chk("rstwr_ready", 64'(ready), 64'd0);
        ctl_stall = 1'b0;
        tick(); tick(); tick();
        chk("rstwr_idle", 64'({sram_wr_en, sram_rd_en, count}), 64'd0);

        // Reset while a read is outstanding.
        ctl_stall = 1'b1;
        rd_req = 1'b1; addr = 32'hC00;
        tick();
        tick();
        chk("rstrd_pre_en", 64'(sram_rd_en), 64'd1);
        rst = 1'b0; rd_req = 1'b0;
        tick();
        rst = 1'b1;
        chk("rstrd_en", 64'(sram_rd_en), 64'd0);
        chk("rstrd_ready", 64'(ready), 64'd0);
        chk("rstrd_rdata", rdata, 64'd0);
        ctl_stall = 1'b0;
        tick(); tick(); tick();
        chk("rstrd_idle", 64'({sram_rd_en, ready}), 64'd0);
        chk("rstrd_rdata_hold", rdata, 64'd0);

        // Randomized traffic against the queue model.
        ctl_mem.delete();
        q.delete();
        rd_active = 1'b0; drop_rd = 1'b0; wr_hold = 1'b0; rd_age = 0;
        for (int it = 0; it < 400; it++) begin
            if (drop_rd) begin rd_req = 1'b0; drop_rd = 1'b0; end
            if (!wr_hold && !rd_active) begin
                r  = $urandom_range(0, 3);
                ra = 32'h400 + 32'(4 * $urandom_range(0, 3));
                wr_req = 1'b0;
                if (r < 2) begin
                    wr_req = 1'b1; addr = ra; wdata = $urandom;
                end else if (r == 2) begin
                    rd_req = 1'b1; addr = ra; rd_active = 1'b1; rd_age = 0;
                end
            end
            ctl_lat = $urandom_range(1, 3);
            #1;
            exp_acc = wr_req && (q.size() < DEPTH);
            if (wr_req) chk("rnd_wr_ready", 64'(ready), 64'(exp_acc));
            chk("rnd_count", 64'(count), 64'(q.size()));
            chk("rnd_empty", 64'(empty), 64'(q.size() == 0));
            if (sram_wr_en)
                chk("rnd_wr_head", {sram_addr, sram_wdata},
                    q.size() > 0 ? q[0] : ~{sram_addr, sram_wdata});
            if (sram_rd_en) chk("rnd_rd_after_drain", 64'(q.size()), 64'd0);
            if (rd_active) begin
                if (ready) begin
                    exp_rd = mdl_last.exists(addr) ?
                             mem_word(addr, mdl_last[addr]) : mem_default(addr);
                    chk("rnd_rdata", rdata, exp_rd);
                    rd_active = 1'b0;
                    drop_rd = 1'b1;
                end else if (++rd_age > 60) begin
                    chk("rnd_rd_timeout", 64'd0, 64'd1);
                    rd_active = 1'b0;
                    rd_req = 1'b0;
                end
            end
            wr_hold = wr_req && !exp_acc;
            tick();
            if (ctl_wr_done && q.size() > 0) void'(q.pop_front());
            if (exp_acc) begin
                q.push_back({addr, wdata});
                mdl_last[addr] = wdata;
                wr_req = 1'b0;
            end
        end
        wr_req = 1'b0;
        rd_req = 1'b0;
        drain(100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
